// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback unit and its long-result FIFO.
package wb_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
    logic                      isLong;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LONG
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; DEPTH must be a power of two >= 2.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push_i,
  input  wb_entry_t push_entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  wb_entry_t     mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push while full is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port: merges ALU and buffered long-unit results, tracks pending long destinations.
// Optional macro WB_BYPASS_EN lets a long result skip the empty FIFO straight into the output register.
module writeback_unit #(
  parameter int DATA_WIDTH      = wb_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH  = wb_pkg::REG_ADDR_WIDTH,
  parameter int LONG_FIFO_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      aluValid,
  input  logic [REG_ADDR_WIDTH-1:0] aluRd,
  input  logic [DATA_WIDTH-1:0]     aluData,
  input  logic                      longValid,
  input  logic [REG_ADDR_WIDTH-1:0] longRd,
  input  logic [DATA_WIDTH-1:0]     longData,
  output logic                      longReady,
  input  logic                      issueLongValid,
  input  logic [REG_ADDR_WIDTH-1:0] issueLongRd,
  input  logic [REG_ADDR_WIDTH-1:0] queryRs1,
  input  logic [REG_ADDR_WIDTH-1:0] queryRs2,
  output logic                      busyRs1,
  output logic                      busyRs2,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]     writeData,
  output logic                      registerWrite
);
  import wb_pkg::*;

  localparam int NREGS = 1 << REG_ADDR_WIDTH;

  wb_entry_t  fifo_head;
  wb_entry_t  long_entry;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       bypass;

  wb_src_e    sel;
  wb_entry_t  out_q, out_d;
  logic       wr_q, wr_d;
  logic [NREGS-1:0] pending_q, pending_d;

  assign long_entry = '{rd: longRd, data: longData, isLong: 1'b1};

`ifdef WB_BYPASS_EN
  assign bypass    = !aluValid && fifo_empty && longValid;
  // When full but the ALU is idle, the head is popped this cycle so one slot frees up.
  assign longReady = !reset && (!fifo_full || !aluValid);
`else
  assign bypass    = 1'b0;
  assign longReady = !reset && !fifo_full;
`endif

  // Handshake: a long result transfers on a rising edge where longValid && longReady.
  assign fifo_push = longValid && longReady && !bypass;
  assign fifo_pop  = !aluValid && !fifo_empty;

  wb_fifo #(
    .DEPTH(LONG_FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_entry_i(long_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    sel   = WB_NONE;
    out_d = out_q;
    if (aluValid) begin
      sel   = WB_ALU;
      out_d = '{rd: aluRd, data: aluData, isLong: 1'b0};
    end else if (fifo_pop) begin
      sel   = WB_LONG;
      out_d = fifo_head;
    end else if (bypass) begin
      sel   = WB_LONG;
      out_d = long_entry;
    end
    // x0 destinations are consumed without writing.
    wr_d = (sel != WB_NONE) && (out_d.rd != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      wr_q  <= wr_d;
    end
  end

  assign rd            = out_q.rd;
  assign writeData     = out_q.data;
  assign registerWrite = wr_q;

  // Clear on the edge the register file captures the long result; a new issue wins over a clear.
  always_comb begin
    pending_d = pending_q;
    if (wr_q && out_q.isLong) pending_d[out_q.rd] = 1'b0;
    if (issueLongValid && (issueLongRd != '0)) pending_d[issueLongRd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign busyRs1 = (queryRs1 != '0) && pending_q[queryRs1];
  assign busyRs2 = (queryRs2 != '0) && pending_q[queryRs2];

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (issueLongValid && (issueLongRd != '0))
        assert (!pending_q[issueLongRd])
          else $error("writeback_unit: long issue to already pending rd %0d", issueLongRd);
      if (aluValid && (aluRd != '0))
        assert (!pending_q[aluRd])
          else $error("writeback_unit: ALU write to pending rd %0d", aluRd);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (default build, no long-result bypass).
module tb_writeback_unit;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          aluValid;
  logic [AW-1:0] aluRd;
  logic [DW-1:0] aluData;
  logic          longValid;
  logic [AW-1:0] longRd;
  logic [DW-1:0] longData;
  logic          longReady;
  logic          issueLongValid;
  logic [AW-1:0] issueLongRd;
  logic [AW-1:0] queryRs1;
  logic [AW-1:0] queryRs2;
  logic          busyRs1;
  logic          busyRs2;
  logic [AW-1:0] rd;
  logic [DW-1:0] writeData;
  logic          registerWrite;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clock = ~clock;

  writeback_unit #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .LONG_FIFO_DEPTH(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .aluValid      (aluValid),
    .aluRd         (aluRd),
    .aluData       (aluData),
    .longValid     (longValid),
    .longRd        (longRd),
    .longData      (longData),
    .longReady     (longReady),
    .issueLongValid(issueLongValid),
    .issueLongRd   (issueLongRd),
    .queryRs1      (queryRs1),
    .queryRs2      (queryRs2),
    .busyRs1       (busyRs1),
    .busyRs2       (busyRs2),
    .rd            (rd),
    .writeData     (writeData),
    .registerWrite (registerWrite)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and registered outputs are sampled here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    aluValid       = 1'b0;
    aluRd          = '0;
    aluData        = '0;
    longValid      = 1'b0;
    longRd         = '0;
    longData       = '0;
    issueLongValid = 1'b0;
    issueLongRd    = '0;
  endtask

  initial begin
    logic [AW+DW-1:0] e;
    int acc;

    reset    = 1'b1;
    queryRs1 = '0;
    queryRs2 = '0;
    idle_inputs();

    // Reset then idle
    tick();
    tick();
    check("reset_ready_low", longReady, 0);
    reset = 1'b0;
    #1;
    check("reset_wr", registerWrite, 0);
    check("reset_rd", rd, 0);
    check("reset_data", writeData, 0);
    check("reset_ready", longReady, 1);
    check("reset_busy1", busyRs1, 0);
    check("reset_busy2", busyRs2, 0);

    // Single ALU write, one-cycle latency
    tick();
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF;
    tick();
    idle_inputs();
    check("alu_wr", registerWrite, 1);
    check("alu_rd", rd, 5);
    check("alu_data", writeData, 32'hDEADBEEF);
    tick();
    check("alu_wr_drop", registerWrite, 0);
    check("alu_rd_hold", rd, 5);
    check("alu_data_hold", writeData, 32'hDEADBEEF);

    // Long op: issue, busy, push, 2-cycle write, busy clears after
    issueLongValid = 1'b1; issueLongRd = 5'd7;
    tick();
    idle_inputs();
    queryRs1 = 5'd7;
    queryRs2 = 5'd6;
    #1;
    check("issue_busy1", busyRs1, 1);
    check("issue_busy2_other", busyRs2, 0);
    longValid = 1'b1; longRd = 5'd7; longData = 32'h12345678;
    #1;
    check("long_ready", longReady, 1);
    tick();
    idle_inputs();
    check("long_c1_wr", registerWrite, 0);
    check("long_c1_busy", busyRs1, 1);
    tick();
    check("long_c2_wr", registerWrite, 1);
    check("long_c2_rd", rd, 7);
    check("long_c2_data", writeData, 32'h12345678);
    check("long_c2_busy", busyRs1, 1);
    tick();
    check("long_c3_wr", registerWrite, 0);
    check("long_c3_busy", busyRs1, 0);

    // ALU and long in the same cycle: ALU first
    aluValid = 1'b1; aluRd = 5'd3; aluData = 32'h33;
    longValid = 1'b1; longRd = 5'd9; longData = 32'h99;
    tick();
    idle_inputs();
    check("same_alu_wr", registerWrite, 1);
    check("same_alu_rd", rd, 3);
    check("same_alu_data", writeData, 32'h33);
    tick();
    check("same_long_wr", registerWrite, 1);
    check("same_long_rd", rd, 9);
    check("same_long_data", writeData, 32'h99);
    tick();
    check("same_idle_wr", registerWrite, 0);

    // x0: ALU to x0 and issue to x0, then a long result to x0
    queryRs1 = '0;
    aluValid = 1'b1; aluRd = '0; aluData = 32'hFFFFFFFF;
    issueLongValid = 1'b1; issueLongRd = '0;
    tick();
    idle_inputs();
    check("x0_alu_wr", registerWrite, 0);
    check("x0_busy1", busyRs1, 0);
    longValid = 1'b1; longRd = '0; longData = 32'h55;
    tick();
    idle_inputs();
    check("x0_long_c1_wr", registerWrite, 0);
    tick();
    check("x0_long_c2_wr", registerWrite, 0);
    tick();
    check("x0_long_c3_wr", registerWrite, 0);
    check("x0_fifo_empty_ready", longReady, 1);

    // ALU burst of 6 while 5 long results are offered: FIFO fills at 4
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      aluValid = 1'b1; aluRd = AW'(10 + i); aluData = 32'hA100 + i;
      longValid = 1'b1; longRd = AW'(20 + acc); longData = 32'hB000 + acc;
      #1;
      check("burst_ready", longReady, (acc < 4) ? 1 : 0);
      tick();
      if (acc < 4) begin
        exp_q.push_back({longRd, longData});
        acc++;
      end
      check("burst_wr", registerWrite, 1);
      check("burst_rd", rd, 10 + i);
      check("burst_data", writeData, 32'hA100 + i);
    end
    idle_inputs();
    for (int j = 0; j < 4; j++) begin
      tick();
      e = exp_q.pop_front();
      check("drain_wr", registerWrite, 1);
      check("drain_rd", rd, e[DW +: AW]);
      check("drain_data", writeData, e[DW-1:0]);
    end
    tick();
    check("drain_done_wr", registerWrite, 0);
    check("drain_done_ready", longReady, 1);

    // Reset mid-operation discards queued results and pending bits
    queryRs1 = 5'd12;
    issueLongValid = 1'b1; issueLongRd = 5'd12;
    aluValid = 1'b1; aluRd = 5'd1; aluData = 32'h11;
    longValid = 1'b1; longRd = 5'd2; longData = 32'h22;
    tick();
    issueLongValid = 1'b0; issueLongRd = '0;
    check("mid_busy_before", busyRs1, 1);
    tick();
    idle_inputs();
    reset = 1'b1;
    #1;
    check("mid_ready_in_reset", longReady, 0);
    tick();
    check("mid_reset_wr", registerWrite, 0);
    check("mid_reset_rd", rd, 0);
    check("mid_reset_data", writeData, 0);
    check("mid_reset_busy", busyRs1, 0);
    reset = 1'b0;
    tick();
    check("mid_after_wr", registerWrite, 0);
    check("mid_after_ready", longReady, 1);
    tick();
    check("mid_after2_wr", registerWrite, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
